// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU program sequencer.
// Holds the opcode set understood by alu_core and the state encoding
// used by the sequencer state machine.
package alu_seq_pkg;

  // Opcodes as stored in the top OPW bits of every program word.
  typedef enum logic [2:0] {
    ADD   = 3'd0,
    SUB   = 3'd1,
    AND   = 3'd2,
    OR    = 3'd3,
    XOR   = 3'd4,
    NOTA  = 3'd5,
    SHL   = 3'd6,
    PASSB = 3'd7
  } op_e;

  // Sequencer states: FETCH reads memory, EXEC registers the ALU result,
  // WAIT spaces out executions during an auto sweep.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    WAIT  = 2'd3
  } state_e;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU used by the program sequencer.
// Ports:
//   A, B   : WIDTH-bit operands
//   op     : opcode (op_e)
//   C      : WIDTH-bit result, truncated
//   carry  : carry out (ADD), borrow (SUB), shifted-out bit (SHL), else 0
//   ovf    : signed overflow for ADD/SUB, else 0
module alu_core
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  op_e              op,
  output logic [WIDTH-1:0] C,
  output logic             carry,
  output logic             ovf
);

  // One extra bit so the carry/borrow falls out of the arithmetic.
  logic [WIDTH:0] ext;

  always_comb begin
    ext   = '0;
    C     = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    case (op)
      ADD: begin
        ext   = {1'b0, A} + {1'b0, B};
        C     = ext[WIDTH-1:0];
        carry = ext[WIDTH];
        // Same-sign operands producing a different-sign result.
        ovf   = (A[WIDTH-1] == B[WIDTH-1]) && (C[WIDTH-1] != A[WIDTH-1]);
      end
      SUB: begin
        // The extended top bit is set exactly when A < B, i.e. a borrow.
        ext   = {1'b0, A} - {1'b0, B};
        C     = ext[WIDTH-1:0];
        carry = ext[WIDTH];
        ovf   = (A[WIDTH-1] != B[WIDTH-1]) && (C[WIDTH-1] != A[WIDTH-1]);
      end
      AND:   C = A & B;
      OR:    C = A | B;
      XOR:   C = A ^ B;
      NOTA:  C = ~A;
      SHL: begin
        C     = {A[WIDTH-2:0], 1'b0};
        carry = A[WIDTH-1];
      end
      PASSB: C = B;
      default: C = '0;
    endcase
  end

endmodule

// File: rtl/alu_program_sequencer.sv
// Program-memory ALU sequencer.
// A DEPTH-entry memory of {op, A, B} words is filled from the switches one
// key press at a time (rw=1). With rw=0 each press executes one entry
// (step mode) or starts a sweep over the whole program, one execution every
// STEP_CYCLES cycles (auto mode). Result, operands and flags are registered.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   i_data        : switch word {op, A, B}, op in the MSBs
//   key           : synchronised pushbutton level, 1 = pressed
//   rw            : 1 = load program, 0 = execute
//   auto_run      : in execute, 0 = step, 1 = auto sweep
//   instr, A, B   : opcode and operands of the last executed entry
//   C             : registered result
//   carry/zero/ovf: result flags
//   addr          : write pointer when rw=1, else read pointer
//   result_valid  : one-cycle pulse per execution
//   done          : one-cycle pulse when an auto sweep completes
//   empty         : program count is zero
//   busy          : state machine is not IDLE
module alu_program_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH       = 6,
  parameter int DEPTH       = 8,
  parameter int OPW         = 3,
  parameter int STEP_CYCLES = 50000000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [OPW+2*WIDTH-1:0]   i_data,
  input  logic                     key,
  input  logic                     rw,
  input  logic                     auto_run,
  output logic [OPW-1:0]           instr,
  output logic [WIDTH-1:0]         A,
  output logic [WIDTH-1:0]         B,
  output logic [WIDTH-1:0]         C,
  output logic                     carry,
  output logic                     zero,
  output logic                     ovf,
  output logic [$clog2(DEPTH)-1:0] addr,
  output logic                     result_valid,
  output logic                     done,
  output logic                     empty,
  output logic                     busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = OPW + 2 * WIDTH;
  // WAIT lasts STEP_CYCLES-2 cycles; with STEP_CYCLES=2 it is skipped.
  localparam bit HAS_WAIT = (STEP_CYCLES > 2);
  localparam int WCW = HAS_WAIT ? $clog2(STEP_CYCLES) : 1;
  localparam logic [WCW-1:0] WAIT_LOAD = WCW'(HAS_WAIT ? STEP_CYCLES - 3 : 0);

  logic [DW-1:0]    mem [DEPTH];
  logic [DW-1:0]    mem_q;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    eff_ptr;
  logic [AW-1:0]    next_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    remaining;
  logic [WCW-1:0]   wait_cnt;
  state_e           state;
  logic             key_q;
  logic             sweep;
  logic             press;
  logic             load;
  logic             abort;

  logic [OPW-1:0]   op_f;
  logic [WIDTH-1:0] a_f;
  logic [WIDTH-1:0] b_f;
  logic [WIDTH-1:0] alu_c;
  logic             alu_carry;
  logic             alu_ovf;

  assign press = key & ~key_q;
  assign load  = rw & press;
  // Switching to load mode cancels a running sweep.
  assign abort = sweep & rw;

  assign op_f = mem_q[DW-1 -: OPW];
  assign a_f  = mem_q[2*WIDTH-1 -: WIDTH];
  assign b_f  = mem_q[WIDTH-1:0];

  // The program may have shrunk below rd_ptr after a reload, so the fetch
  // restarts from entry 0 in that case; advancing wraps at count.
  assign eff_ptr  = ({1'b0, rd_ptr} >= count) ? '0 : rd_ptr;
  assign next_ptr = (({1'b0, rd_ptr} + CW'(1)) >= count) ? '0 : rd_ptr + 1'b1;

  assign addr  = rw ? wr_ptr : rd_ptr;
  assign empty = (count == '0);
  assign busy  = (state != IDLE);

  alu_core #(
    .WIDTH(WIDTH)
  ) u_alu (
    .A    (a_f),
    .B    (b_f),
    .op   (op_e'(op_f)),
    .C    (alu_c),
    .carry(alu_carry),
    .ovf  (alu_ovf)
  );

  // Program memory write port; no reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (!rst && load) begin
      mem[wr_ptr] <= i_data;
    end
  end

  // Sequencer: press detection, load bookkeeping, and the FETCH/EXEC/WAIT
  // state machine with all visible outputs registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      key_q        <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      remaining    <= '0;
      wait_cnt     <= '0;
      sweep        <= 1'b0;
      mem_q        <= '0;
      instr        <= '0;
      A            <= '0;
      B            <= '0;
      C            <= '0;
      carry        <= 1'b0;
      zero         <= 1'b0;
      ovf          <= 1'b0;
      result_valid <= 1'b0;
      done         <= 1'b0;
    end else begin
      key_q        <= key;
      result_valid <= 1'b0;
      done         <= 1'b0;

      if (load) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (count != CW'(DEPTH)) begin
          count <= count + CW'(1);
        end
      end

      case (state)
        IDLE: begin
          if (press && !rw && count != '0) begin
            state     <= FETCH;
            sweep     <= auto_run;
            remaining <= count;
            if (auto_run) begin
              rd_ptr <= '0;
            end
          end
        end
        FETCH: begin
          if (abort) begin
            state <= IDLE;
            sweep <= 1'b0;
          end else begin
            mem_q  <= mem[eff_ptr];
            rd_ptr <= eff_ptr;
            state  <= EXEC;
          end
        end
        EXEC: begin
          if (abort) begin
            state <= IDLE;
            sweep <= 1'b0;
          end else begin
            C            <= alu_c;
            A            <= a_f;
            B            <= b_f;
            instr        <= op_f;
            carry        <= alu_carry;
            ovf          <= alu_ovf;
            zero         <= (alu_c == '0);
            result_valid <= 1'b1;
            rd_ptr       <= next_ptr;
            remaining    <= remaining - CW'(1);
            if (sweep && remaining > CW'(1)) begin
              if (HAS_WAIT) begin
                state    <= WAIT;
                wait_cnt <= WAIT_LOAD;
              end else begin
                state <= FETCH;
              end
            end else begin
              state <= IDLE;
              done  <= sweep;
              sweep <= 1'b0;
            end
          end
        end
        WAIT: begin
          if (abort) begin
            state <= IDLE;
            sweep <= 1'b0;
          end else if (wait_cnt == '0) begin
            state <= FETCH;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_program_sequencer.sv
// Randomised scoreboard bench for alu_program_sequencer (WIDTH=6, DEPTH=8,
// STEP_CYCLES=4). Each press is fed to a program-level model that predicts
// which entries execute and on which clock edge; a monitor checks every
// result_valid pulse against the predictions.
module tb_alu_program_sequencer;

  localparam int W   = 6;
  localparam int D   = 8;
  localparam int SC  = 4;
  localparam int MOD = 1 << W;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [14:0] i_data = '0;
  logic        key = 1'b0;
  logic        rw = 1'b0;
  logic        auto_run = 1'b0;
  logic [2:0]  instr;
  logic [5:0]  A, B, C;
  logic        carry, zero, ovf;
  logic [2:0]  addr;
  logic        result_valid, done, empty, busy;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  typedef struct {
    int c; int carry; int zero; int ovf;
    int op; int a; int b; int done; int at_cycle;
  } exp_t;
  exp_t sbq[$];

  // Program-level model state
  int prog[D];
  int m_count = 0;
  int m_wr = 0;
  int m_rd = 0;
  int m_busy_until = 0;

  alu_program_sequencer #(
    .WIDTH(W), .DEPTH(D), .OPW(3), .STEP_CYCLES(SC)
  ) dut (
    .clk(clk), .rst(rst), .i_data(i_data), .key(key), .rw(rw),
    .auto_run(auto_run), .instr(instr), .A(A), .B(B), .C(C),
    .carry(carry), .zero(zero), .ovf(ovf), .addr(addr),
    .result_valid(result_valid), .done(done), .empty(empty), .busy(busy)
  );

  always #5 clk = ~clk;

  // Edge counter: after posedge k the value is k.
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic int to_signed(input int v);
    return (v >= MOD / 2) ? v - MOD : v;
  endfunction

  // Push the expected outcome of executing one program word at edge 'at'.
  task automatic model_exec(input int word, input int at, input int dn);
    exp_t e;
    int op, a, b, s, c, cy, ov;
    op = (word >> 12) & 7;
    a  = (word >> 6) & (MOD - 1);
    b  = word & (MOD - 1);
    cy = 0;
    ov = 0;
    case (op)
      0: begin
        s = a + b; c = s % MOD; cy = (s >= MOD) ? 1 : 0;
        s = to_signed(a) + to_signed(b);
        ov = (s > MOD / 2 - 1 || s < -MOD / 2) ? 1 : 0;
      end
      1: begin
        c = (a - b + MOD) % MOD; cy = (a < b) ? 1 : 0;
        s = to_signed(a) - to_signed(b);
        ov = (s > MOD / 2 - 1 || s < -MOD / 2) ? 1 : 0;
      end
      2: c = a & b;
      3: c = a | b;
      4: c = a ^ b;
      5: c = (MOD - 1) - a;
      6: begin c = (a * 2) % MOD; cy = (a >= MOD / 2) ? 1 : 0; end
      default: c = b;
    endcase
    e.c = c; e.carry = cy; e.zero = (c == 0) ? 1 : 0; e.ovf = ov;
    e.op = op; e.a = a; e.b = b; e.done = dn; e.at_cycle = at;
    sbq.push_back(e);
  endtask

  // Model reaction to a press detected at edge p.
  task automatic model_press(input int p, input int r, input int au, input int word);
    int eff;
    if (r != 0) begin
      prog[m_wr] = word;
      m_wr = (m_wr + 1) % D;
      if (m_count < D) m_count++;
    end else if (m_count == 0 || p <= m_busy_until) begin
      // ignored: empty program or sequencer busy
    end else if (au == 0) begin
      eff = (m_rd >= m_count) ? 0 : m_rd;
      model_exec(prog[eff], p + 2, 0);
      m_rd = (eff + 1) % m_count;
      m_busy_until = p + 2;
    end else begin
      for (int k = 0; k < m_count; k++)
        model_exec(prog[k], p + 2 + SC * k, (k == m_count - 1) ? 1 : 0);
      m_rd = 0;
      m_busy_until = p + 2 + SC * (m_count - 1);
    end
  endtask

  task automatic model_reset();
    m_count = 0; m_wr = 0; m_rd = 0; m_busy_until = 0;
    sbq.delete();
  endtask

  // One single-edge key press; the press is detected at the edge after key rises.
  task automatic applyStimulus(input int word, input int r, input int au);
    int p;
    @(posedge clk); #1;
    rw = r[0]; auto_run = au[0]; i_data = word[14:0]; key = 1'b1;
    p = cyc + 1;
    model_press(p, r, au, word);
    @(posedge clk); #1;
    key = 1'b0;
  endtask

  task automatic holdKey(input int n);
    int p;
    @(posedge clk); #1;
    rw = 1'b0; auto_run = 1'b0; key = 1'b1;
    p = cyc + 1;
    model_press(p, 0, 0, 0);
    repeat (n) @(posedge clk);
    #1 key = 1'b0;
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while (sbq.size() != 0 && n < bound) begin
      @(posedge clk);
      n++;
    end
    #2;
    if (sbq.size() != 0) begin
      checkOutput("drain_timeout", sbq.size(), 0);
      sbq.delete();
    end
    repeat (3) @(posedge clk);
  endtask

  // Monitor: every result_valid pulse must match the oldest prediction.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (result_valid) begin
      if (sbq.size() == 0) begin
        checkOutput("unexpected_result", 1, 0);
      end else begin
        e = sbq.pop_front();
        checkOutput("result_cycle", cyc, e.at_cycle);
        checkOutput("C", C, e.c);
        checkOutput("carry", carry, e.carry);
        checkOutput("zero", zero, e.zero);
        checkOutput("ovf", ovf, e.ovf);
        checkOutput("instr", instr, e.op);
        checkOutput("A", A, e.a);
        checkOutput("B", B, e.b);
        checkOutput("done", done, e.done);
      end
    end else if (done) begin
      checkOutput("stray_done", 1, 0);
    end
  end

  int w9;

  initial begin
    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_C", C, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_empty", empty, 1);
    checkOutput("rst_addr", addr, 0);
    checkOutput("rst_flags", {carry, zero, ovf}, 0);
    checkOutput("rst_pulses", {result_valid, done}, 0);
    rst = 1'b0;

    // Empty program: execute press ignored
    applyStimulus(0, 0, 0);
    repeat (6) @(posedge clk);
    #1 checkOutput("empty_busy", busy, 0);

    // Load three entries
    applyStimulus((0 << 12) | (30 << 6) | 40, 1, 0);
    applyStimulus((1 << 12) | (5 << 6) | 9, 1, 0);
    applyStimulus((6 << 12) | (33 << 6) | 0, 1, 0);
    checkOutput("load_addr", addr, 3);
    checkOutput("load_empty", empty, 0);

    // Step mode: three presses plus a fourth that wraps to entry 0
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0);
      repeat (3) @(posedge clk);
    end
    drain(20);
    checkOutput("hold_C", C, 6);
    checkOutput("hold_carry", carry, 1);
    checkOutput("hold_ovf", ovf, 0);

    // Held key yields exactly one execution
    holdKey(20);
    drain(20);

    // Auto sweep with an ignored press at +5
    applyStimulus(0, 0, 1);
    repeat (3) @(posedge clk);
    applyStimulus(0, 0, 1);
    drain(40);

    // Reset in the middle of a sweep
    applyStimulus(0, 0, 1);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #2;
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_C", C, 0);
    checkOutput("midrst_empty", empty, 1);
    checkOutput("midrst_done", done, 0);
    model_reset();
    rst = 1'b0;
    repeat (3 * SC) @(posedge clk);

    // Empty after reset: press ignored
    applyStimulus(0, 0, 0);
    repeat (6) @(posedge clk);

    // Nine random loads: count saturates, wr_ptr wraps to 1
    for (int i = 0; i < 9; i++) begin
      w9 = int'($urandom_range(0, 32767));
      applyStimulus(w9, 1, 0);
    end
    checkOutput("wrap_addr", addr, 1);
    checkOutput("wrap_empty", empty, 0);
    applyStimulus(0, 0, 0);
    drain(20);
    checkOutput("wrap_entry0_C_op", instr, (w9 >> 12) & 7);

    // Random step presses with random spacing, then a full 8-entry sweep
    for (int i = 0; i < 12; i++) begin
      applyStimulus(0, 0, 0);
      repeat ($urandom_range(0, 4)) @(posedge clk);
    end
    drain(30);
    applyStimulus(0, 0, 1);
    drain(60);

    // Abort: rw rises mid-sweep, sequencer returns to IDLE, no done
    applyStimulus(0, 0, 1);
    repeat (5) @(posedge clk);
    #1 rw = 1'b1;
    @(posedge clk); #2;
    checkOutput("abort_busy", busy, 0);
    sbq.delete();
    repeat (3 * SC) @(posedge clk);
    #1 checkOutput("abort_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
